// File: rtl/embnew16k_oci_dct_pkg.sv
// embnew16k_oci_dct_pkg: shared widths and FSM states for the OCI DCT atom packer.
package embnew16k_oci_dct_pkg;
  localparam int ATOM_W = 2;
  localparam int SLOTS  = 15;
  localparam int CNT_W  = 4;
  localparam int BUF_W  = ATOM_W * SLOTS;
  localparam int DROP_W = 8;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
endpackage

// File: rtl/embnew16k_oci_dct_outreg.sv
// embnew16k_oci_dct_outreg: single-entry valid/ready holding register for packed frames.
//  i_clk, i_reset_n : clock, async active-low reset
//  i_load           : capture i_data/i_cnt and raise o_valid
//  i_data, i_cnt    : frame payload and atom count
//  i_ready          : downstream accepts the held frame
//  o_valid, o_data, o_cnt : held frame
//  o_busy           : frame held and not being accepted this cycle
module embnew16k_oci_dct_outreg
  import embnew16k_oci_dct_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [BUF_W-1:0] i_data,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [BUF_W-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy
);
  logic             r_valid;
  logic [BUF_W-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_cnt   <= i_cnt;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  assign o_busy  = r_valid & ~i_ready;
endmodule

// File: rtl/embnew16k_nios2_qsys_0_oci_dct_ctrl.sv
// embnew16k_nios2_qsys_0_oci_dct_ctrl: packs 2-bit DCT atoms into 30-bit frames for the trace store.
//  i_clk, i_reset_n        : clock, async active-low reset
//  i_trace_enable          : atoms ignored while low
//  i_atom_valid, i_atom    : incoming trace atom (never stalled)
//  i_flush_req             : pulse, emit current partial frame
//  i_test_ending           : level, final flush then end-of-test
//  o_frame_valid, i_frame_ready, o_dct_buffer, o_dct_count : frame handshake/payload
//  o_overflow, i_overflow_clr, o_drop_cnt : sticky drop flag and saturating drop count
//  o_test_has_ended        : sticky once the final frame has drained
module embnew16k_nios2_qsys_0_oci_dct_ctrl
  import embnew16k_oci_dct_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_trace_enable,
  input  logic              i_atom_valid,
  input  logic [ATOM_W-1:0] i_atom,
  input  logic              i_flush_req,
  input  logic              i_test_ending,
  output logic              o_frame_valid,
  input  logic              i_frame_ready,
  output logic [BUF_W-1:0]  o_dct_buffer,
  output logic [CNT_W-1:0]  o_dct_count,
  output logic              o_overflow,
  input  logic              i_overflow_clr,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_test_has_ended
);
  localparam int TMR_W = $clog2(TIMEOUT);
  state_t             r_state, w_state_nxt;
  logic [BUF_W-1:0]   r_pbuf, w_buf;
  logic [CNT_W-1:0]   r_pcnt, w_n;
  logic [TMR_W-1:0]   r_timer;
  logic [DROP_W-1:0]  r_drop_cnt;
  logic               r_pend, r_overflow;
  logic               w_live, w_acc, w_drop, w_trig, w_xfer, w_busy;
  assign w_live = i_atom_valid & i_trace_enable & (r_state != DONE);
  assign w_acc  = w_live & (r_pcnt < CNT_W'(SLOTS));
  assign w_drop = w_live & ~w_acc;
  // Trigger looks at the post-append count so the same-cycle atom rides along.
  assign w_n    = r_pcnt + CNT_W'(w_acc);
  assign w_trig = (w_n == CNT_W'(SLOTS)) |
                  ((w_n != '0) & (i_flush_req | r_pend | i_test_ending |
                                  (r_state == DRAIN) | (r_timer == TMR_W'(TIMEOUT - 1))));
  assign w_xfer = w_trig & ~w_busy;
  always_comb begin
    w_buf = r_pbuf;
    if (w_acc) w_buf[ATOM_W*r_pcnt +: ATOM_W] = i_atom;
  end
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  w_state_nxt = i_test_ending ? DRAIN : (w_acc & ~w_xfer) ? FILL : IDLE;
      FILL:  w_state_nxt = i_test_ending ? DRAIN : w_xfer ? IDLE : FILL;
      // Only finish once nothing is packed and the last frame has been taken.
      DRAIN: w_state_nxt = ((w_n == '0) & ~o_frame_valid) ? DONE : DRAIN;
      DONE:  w_state_nxt = DONE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_pbuf     <= '0;
      r_pcnt     <= '0;
      r_timer    <= '0;
      r_pend     <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pbuf     <= w_xfer ? '0 : w_buf;
      r_pcnt     <= w_xfer ? '0 : w_n;
      r_timer    <= (w_acc | w_xfer) ? '0 :
                    ((r_pcnt != '0) && (r_timer != TMR_W'(TIMEOUT - 1))) ? r_timer + 1'b1 : r_timer;
      // A flush that cannot go out yet is remembered until the output frees.
      r_pend     <= w_xfer ? 1'b0 : (r_pend | (i_flush_req & (w_n != '0)));
      r_overflow <= i_overflow_clr ? 1'b0 : (r_overflow | w_drop);
      r_drop_cnt <= i_overflow_clr ? '0 :
                    (w_drop && (r_drop_cnt != '1)) ? r_drop_cnt + 1'b1 : r_drop_cnt;
    end
  end
  embnew16k_oci_dct_outreg u_outreg (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_xfer),
    .i_data    (w_buf),
    .i_cnt     (w_n),
    .i_ready   (i_frame_ready),
    .o_valid   (o_frame_valid),
    .o_data    (o_dct_buffer),
    .o_cnt     (o_dct_count),
    .o_busy    (w_busy)
  );
  assign o_overflow       = r_overflow;
  assign o_drop_cnt       = r_drop_cnt;
  assign o_test_has_ended = (r_state == DONE);
endmodule

// File: tb/tb_embnew16k_nios2_qsys_0_oci_dct_ctrl.sv
// tb_embnew16k_nios2_qsys_0_oci_dct_ctrl: scoreboard bench for the DCT atom packer.
module tb_embnew16k_nios2_qsys_0_oci_dct_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        trace_enable = 1'b1, atom_valid = 1'b0, flush_req = 1'b0, test_ending = 1'b0;
  logic        frame_ready = 1'b1, overflow_clr = 1'b0;
  logic [1:0]  atom = '0;
  logic        frame_valid, overflow, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_cnt;
  int          n_tests = 0, n_fail = 0;
  logic [33:0] q[$];
  logic [33:0] m_exp;
  logic [29:0] mbuf = '0;
  int          mcnt = 0;
  embnew16k_nios2_qsys_0_oci_dct_ctrl dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_trace_enable   (trace_enable),
    .i_atom_valid     (atom_valid),
    .i_atom           (atom),
    .i_flush_req      (flush_req),
    .i_test_ending    (test_ending),
    .o_frame_valid    (frame_valid),
    .i_frame_ready    (frame_ready),
    .o_dct_buffer     (dct_buffer),
    .o_dct_count      (dct_count),
    .o_overflow       (overflow),
    .i_overflow_clr   (overflow_clr),
    .o_drop_cnt       (drop_cnt),
    .o_test_has_ended (test_has_ended)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push_model();
    if (mcnt > 0) q.push_back({4'(mcnt), mbuf});
    mbuf = '0;
    mcnt = 0;
  endtask
  // take=1: the packer is expected to keep this atom; the model packs it LSB-first.
  task automatic send(input logic [1:0] a, input bit take);
    atom_valid = 1'b1;
    atom = a;
    if (take) begin
      mbuf[2*mcnt +: 2] = a;
      mcnt++;
      if (mcnt == 15) push_model();
    end
    cyc();
    atom_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (reset_n && frame_valid && frame_ready) begin
      if (q.size() == 0) chk("extra_frame", 32'd1, 32'd0);
      else begin
        m_exp = q.pop_front();
        chk("frame_cnt", 32'(dct_count), 32'(m_exp[33:30]));
        chk("frame_buf", 32'(dct_buffer), 32'(m_exp[29:0]));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    #12;
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_buf", 32'(dct_buffer), 0);
    chk("rst_cnt", 32'(dct_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_end", 32'(test_has_ended), 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    // 1: full frame of 0,1,2,3,... leaves the next cycle
    for (int i = 0; i < 15; i++) send(2'(i % 4), 1'b1);
    chk("t1_valid", 32'(frame_valid), 1);
    // 2: short frame by flush, then an empty flush emits nothing
    for (int i = 0; i < 3; i++) send(2'b11, 1'b1);
    flush_req = 1'b1;
    push_model();
    cyc();
    flush_req = 1'b0;
    chk("t2_valid", 32'(frame_valid), 1);
    chk("t2_cnt", 32'(dct_count), 3);
    chk("t2_buf", 32'(dct_buffer), 32'h3F);
    cyc();
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_empty_flush", 32'(frame_valid), 0);
    end
    // 3: stalled output, second pack fills, one atom dropped
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'($urandom_range(0, 3)), 1'b1);
    for (int i = 0; i < 15; i++) begin
      send(2'($urandom_range(0, 3)), 1'b1);
      chk("t3_hold_valid", 32'(frame_valid), 1);
      chk("t3_hold_buf", 32'(dct_buffer), 32'(q[0][29:0]));
    end
    send(2'b10, 1'b0);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_cnt), 1);
    chk("t3_qlen", q.size(), 2);
    frame_ready = 1'b1;
    repeat (3) cyc();
    chk("t3_drained", q.size(), 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);
    chk("t3_drop_clr", 32'(drop_cnt), 0);
    // 4: idle timeout flush exactly TIMEOUT cycles after the last atom
    for (int i = 0; i < 5; i++) send(2'(i), 1'b1);
    push_model();
    k = 0;
    while (!frame_valid && k < 200) begin
      cyc();
      k++;
    end
    chk("t4_latency", k, 64);
    cyc();
    // 5: end of test with a stalled trace store
    for (int i = 0; i < 7; i++) send(2'(3 - (i % 4)), 1'b1);
    test_ending = 1'b1;
    frame_ready = 1'b0;
    push_model();
    cyc();
    chk("t5_valid", 32'(frame_valid), 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) test_ending = 1'b0;
      cyc();
      if (i % 5 == 0) chk("t5_not_ended", 32'(test_has_ended), 0);
    end
    frame_ready = 1'b1;
    k = 0;
    while (!test_has_ended && k < 20) begin
      cyc();
      k++;
    end
    chk("t5_ended", 32'(test_has_ended), 1);
    chk("t5_q_empty", q.size(), 0);
    for (int i = 0; i < 3; i++) send(2'b01, 1'b0);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    cyc();
    chk("t5_no_frame", 32'(frame_valid), 0);
    chk("t5_drop", 32'(drop_cnt), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_sticky", 32'(test_has_ended), 1);
    // 6: asynchronous reset while a frame is held and a pack is partial
    reset_n = 1'b0;
    #1;
    chk("t6_rst_end", 32'(test_has_ended), 0);
    cyc();
    reset_n = 1'b1;
    frame_ready = 1'b0;
    for (int i = 0; i < 19; i++) send(2'($urandom_range(0, 3)), 1'b1);
    chk("t6_pre_valid", 32'(frame_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(frame_valid), 0);
    chk("t6_buf", 32'(dct_buffer), 0);
    chk("t6_cnt", 32'(dct_count), 0);
    chk("t6_end", 32'(test_has_ended), 0);
    q.delete();
    mbuf = '0;
    mcnt = 0;
    cyc();
    reset_n = 1'b1;
    frame_ready = 1'b1;
    send(2'b10, 1'b1);
    flush_req = 1'b1;
    push_model();
    cyc();
    flush_req = 1'b0;
    chk("t6_slot0_cnt", 32'(dct_count), 1);
    chk("t6_slot0_buf", 32'(dct_buffer), 2);
    repeat (3) cyc();
    chk("final_q_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
